uart_txfifo_ctrl: RTL

//  Read sequencer for the 10-bit x16 UART TX FIFO. Pops one word at a time and

---
 rtl/uart_txfifo_ctrl_if.sv | 26 ++
 rtl/uart_txfifo_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/uart_txfifo_ctrl_if.sv
// Handshake bundle between the TX FIFO read sequencer, the 10-bit x16 TX FIFO
// and the UART transmit shift engine.
interface uart_txfifo_ctrl_if #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned USEDW_W = 4
) ();
  logic [DATA_W-1:0]  fifo_q;
  logic               fifo_empty;
  logic               fifo_full;
  logic [USEDW_W-1:0] fifo_usedw;
  logic               fifo_rdreq;
  logic               fifo_aclr;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_start;
  logic               tx_busy;

  modport master (
    input  fifo_q, fifo_empty, fifo_full, fifo_usedw, tx_busy,
    output fifo_rdreq, fifo_aclr, tx_data, tx_start
  );

  modport slave (
    output fifo_q, fifo_empty, fifo_full, fifo_usedw, tx_busy,
    input  fifo_rdreq, fifo_aclr, tx_data, tx_start
  );
endinterface

// File: rtl/uart_txfifo_ctrl.sv
// UART TX FIFO read sequencer: pops one word per frame, hands it off with a
// start/busy handshake, flushes via fifo_aclr. Define UART_TXF_WMARK_EN for wmark_irq.
module uart_txfifo_ctrl #(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned USEDW_W      = 4,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WMARK        = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               enable,
  input  logic               flush,
  uart_txfifo_ctrl_if.master bus,
  output logic               ctrl_busy,
  output logic [CNT_W-1:0]   tx_count,
  output logic               wmark_irq
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] CAP   = 3'd2;
  localparam logic [2:0] REQ   = 3'd3;
  localparam logic [2:0] WAITD = 3'd4;
  localparam logic [2:0] FLUSH = 3'd5;

  localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam int unsigned LVL_W   = USEDW_W + 1;
  localparam logic [LVL_W-1:0] WMARK_L = LVL_W'(WMARK);

  logic [2:0]        state_q, state_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  tx_count_q, tx_count_d;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
    if (flush) begin
      state_d    = FLUSH;
      fcnt_d     = FC_LAST;
      tx_count_d = '0;
    end else begin
      case (state_q)
        IDLE:  if (enable && !bus.fifo_empty && !bus.tx_busy) state_d = RD;
        // FIFO drained underneath us (external clear): abandon the pop.
        RD:    state_d = bus.fifo_empty ? IDLE : CAP;
        CAP: begin
          tx_data_d = bus.fifo_q;
          state_d   = REQ;
        end
        REQ: begin
          if (bus.tx_busy) begin
            tx_count_d = tx_count_q + 1'b1;
            state_d    = WAITD;
          end
        end
        WAITD: if (!bus.tx_busy) state_d = IDLE;
        FLUSH: begin
          if (fcnt_q == '0) state_d = bus.tx_busy ? WAITD : IDLE;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= IDLE;
      fcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      tx_data_q  <= tx_data_d;
      tx_count_q <= tx_count_d;
    end
  end

  // A same-cycle flush suppresses the pop so no word is lost half-read.
  assign bus.fifo_rdreq = (state_q == RD) && !bus.fifo_empty && !flush;
  assign bus.fifo_aclr  = !aclr_n || (state_q == FLUSH);
  assign bus.tx_start   = (state_q == REQ);
  assign bus.tx_data    = tx_data_q;
  assign ctrl_busy      = (state_q != IDLE);
  assign tx_count       = tx_count_q;

`ifdef UART_TXF_WMARK_EN
  logic [LVL_W-1:0] level;
  logic             wmark_q, wmark_d;

  // fifo_usedw wraps to 0 when full, so the full flag supplies the MSB.
  assign level   = {bus.fifo_full, bus.fifo_usedw};
  assign wmark_d = (level < WMARK_L) && enable && (state_d != FLUSH);

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) wmark_q <= 1'b0;
    else         wmark_q <= wmark_d;
  end

  assign wmark_irq = wmark_q;
`else
  logic unused_level;
  assign unused_level = ^{bus.fifo_full, bus.fifo_usedw, WMARK_L};
  assign wmark_irq    = 1'b0;
`endif

endmodule
